// File: rtl/cdr_pkg.sv
// Shared types and sizing helpers for the phase_cdr clock/data recovery stage.
// PHASE_W_DFLT fixes the width of the package-level phase types.
package cdr_pkg;

    localparam int PHASE_W_DFLT = 8;

    typedef logic        [PHASE_W_DFLT-1:0] phase_t;
    typedef logic signed [PHASE_W_DFLT-1:0] dphi_t;

    typedef enum logic {
        S_PRIME,
        S_TRACK
    } state_t;

    // Accumulator width: one bit period of worst-case phase steps plus a sign bit.
    function automatic int acc_width(input int phase_w, input int sps);
        return phase_w + $clog2(sps + 1) + 1;
    endfunction

endpackage

// File: rtl/cdr_timing_loop.sv
// Symbol timing loop: sample counter, transition detector, error integrator and length selection.
// Lock detection is built only when LOCK_DETECT_EN is defined; otherwise lock is tied to 0.
module cdr_timing_loop
    import cdr_pkg::*;
#(
    parameter int PHASE_W  = 8,
    parameter int SPS      = 5,
    parameter int LOOP_TH  = 4,
    parameter int LOCK_CNT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      smp_valid,
    input  logic signed [PHASE_W-1:0] dphi,
    output logic                      sym_end,
    output logic                      lock
);

    localparam int CNT_W = $clog2(SPS + 2);
    localparam int ERR_W = $clog2(LOOP_TH + 2) + 1;

    localparam logic [CNT_W-1:0] LEN_NOM   = CNT_W'(SPS);
    localparam logic [CNT_W-1:0] LEN_SHORT = CNT_W'(SPS - 1);
    localparam logic [CNT_W-1:0] LEN_LONG  = CNT_W'(SPS + 1);
    localparam logic [CNT_W-1:0] HALF      = CNT_W'(SPS / 2);

    localparam logic signed [ERR_W-1:0] TH_P = ERR_W'(LOOP_TH);
    localparam logic signed [ERR_W-1:0] TH_N = -TH_P;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic signed [ERR_W-1:0] err_q, err_d;
    logic signed [ERR_W-1:0] err_sum, err_sat;
    logic                    adj_q, adj_d;
    logic                    sgn_q, sgn_d;
    logic                    sgn_vld_q, sgn_vld_d;
    logic                    nonzero, negative, transition;

    assign nonzero    = (dphi != '0);
    assign negative   = dphi[PHASE_W-1];
    assign transition = sgn_vld_q && nonzero && (negative != sgn_q);
    assign sym_end    = smp_valid && (cnt_q >= len_q - CNT_W'(1));

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        cnt_d     = cnt_q;
        len_d     = len_q;
        err_d     = err_q;
        adj_d     = adj_q;
        sgn_d     = sgn_q;
        sgn_vld_d = sgn_vld_q;
        err_sum   = err_q;
        err_sat   = err_q;

        if (smp_valid) begin
            if (nonzero) begin
                sgn_d     = negative;
                sgn_vld_d = 1'b1;
            end
            if (sym_end) begin
                cnt_d = '0;
                len_d = LEN_NOM;
                adj_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                // Early transitions mean data lags the counter, so the symbol must stretch.
                if (transition && (cnt_q != '0)) begin
                    if (cnt_q <= HALF) err_sum = err_q - ERR_W'(1);
                    else               err_sum = err_q + ERR_W'(1);
                end
                if (err_sum > TH_P)      err_sat = TH_P;
                else if (err_sum < TH_N) err_sat = TH_N;
                else                     err_sat = err_sum;
                err_d = err_sat;
                if (!adj_q && ((err_sat == TH_P) || (err_sat == TH_N))) begin
                    len_d = (err_sat == TH_P) ? LEN_SHORT : LEN_LONG;
                    err_d = '0;
                    adj_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
        if (reset) begin
            cnt_q     <= '0;
            len_q     <= LEN_NOM;
            err_q     <= '0;
            adj_q     <= 1'b0;
            sgn_q     <= 1'b0;
            sgn_vld_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            err_q     <= err_d;
            adj_q     <= adj_d;
            sgn_q     <= sgn_d;
            sgn_vld_q <= sgn_vld_d;
        end
    end

`ifdef LOCK_DETECT_EN
    localparam int              LK_W     = $clog2(LOCK_CNT + 1);
    localparam logic [LK_W-1:0] LOCK_MAX = LK_W'(LOCK_CNT);

    logic [LK_W-1:0] lk_cnt_q, lk_cnt_d;
    logic            lock_q, lock_d;
    logic            drop_q, drop_d;

    // An adjusted symbol drops lock one cycle after its own decision pulse.
    always_comb begin
        lk_cnt_d = lk_cnt_q;
        lock_d   = lock_q;
        drop_d   = 1'b0;
        if (drop_q) lock_d = 1'b0;
        if (sym_end) begin
            if (adj_q) begin
                lk_cnt_d = '0;
                drop_d   = 1'b1;
            end else if (lk_cnt_q != LOCK_MAX) begin
                lk_cnt_d = lk_cnt_q + LK_W'(1);
                if (lk_cnt_q == LOCK_MAX - LK_W'(1)) lock_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lk_cnt_q <= '0;
            lock_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            lk_cnt_q <= lk_cnt_d;
            lock_q   <= lock_d;
            drop_q   <= drop_d;
        end
    end

    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

endmodule

// File: rtl/phase_cdr.sv
// phase_cdr: differentiates wrapped CORDIC phase, integrates one bit period and slices bits.
// Define LOCK_DETECT_EN to build the lock detector inside cdr_timing_loop.
module phase_cdr
    import cdr_pkg::*;
#(
    parameter int PHASE_W  = 8,
    parameter int SPS      = 5,
    parameter int LOOP_TH  = 4,
    parameter int LOCK_CNT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PHASE_W-1:0] phase,
    input  logic               iValid,
    output logic               bitstream,
    output logic               bitstream_en,
    output logic               lock
);

    localparam int ACC_W = acc_width(PHASE_W, SPS);
    localparam int EXT_W = ACC_W - PHASE_W;

    state_t                  state_q, state_d;
    logic [PHASE_W-1:0]      prev_q, prev_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic signed [PHASE_W-1:0] dphi;
    logic                    bit_q, bit_d;
    logic                    bit_en_q, bit_en_d;
    logic                    trk_valid;
    logic                    sym_end;

    // Modulo subtraction gives the wrapped phase step directly; its MSB is the sign.
    assign dphi      = phase - prev_q;
    assign trk_valid = iValid && (state_q == S_TRACK);
    assign acc_sum   = acc_q + {{EXT_W{dphi[PHASE_W-1]}}, dphi};

    cdr_timing_loop #(
        .PHASE_W  (PHASE_W),
        .SPS      (SPS),
        .LOOP_TH  (LOOP_TH),
        .LOCK_CNT (LOCK_CNT)
    ) u_timing_loop (
        .clk       (clk),
        .reset     (reset),
        .smp_valid (trk_valid),
        .dphi      (dphi),
        .sym_end   (sym_end),
        .lock      (lock)
    );

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        acc_d    = acc_q;
        bit_d    = bit_q;
        bit_en_d = 1'b0;

        if (iValid) begin
            prev_d = phase;
            case (state_q)
                S_PRIME: state_d = S_TRACK;
                S_TRACK: begin
                    if (sym_end) begin
                        bit_d    = !acc_sum[ACC_W-1] && (acc_sum != '0);
                        bit_en_d = 1'b1;
                        acc_d    = '0;
                    end else begin
                        acc_d = acc_sum;
                    end
                end
                default: state_d = S_PRIME;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_PRIME;
            prev_q   <= '0;
            acc_q    <= '0;
            bit_q    <= 1'b0;
            bit_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            acc_q    <= acc_d;
            bit_q    <= bit_d;
            bit_en_q <= bit_en_d;
        end
    end

    assign bitstream    = bit_q;
    assign bitstream_en = bit_en_q;

endmodule
